// File: rtl/shift_sequencer.sv
// Multi-cycle left shifter: accepts an operand and shift amount, shifts by two
// positions per clock (one on the final odd step) and holds the result until taken.
module shift_sequencer #(
    parameter int n  = 32,
    parameter int sw = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [n-1:0]  din,
    input  logic [sw-1:0] shamt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [n-1:0]  dout,
    output logic          busy
);

    // Handshakes: a transfer occurs on a rising edge where valid and ready are both
    // high; valid and its payload stay put until that edge, and ready never depends on valid.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [n-1:0]  data_q;
    logic [n-1:0]  data_d;
    logic [sw-1:0] count_q;
    logic [sw-1:0] count_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            state   <= state_next;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_next = state;
        data_d     = data_q;
        count_d    = count_q;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    data_d     = din;
                    count_d    = shamt;
                    state_next = (shamt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                // Comparing against 1 rather than 2 keeps the test correct when sw is 1.
                if (count_q > sw'(1)) begin
                    data_d  = data_q << 2;
                    count_d = count_q - sw'(2);
                end else begin
                    data_d  = data_q << 1;
                    count_d = '0;
                end
                if (count_d == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state == SHIFT);
        out_valid = (state == DONE);
        dout      = data_q;
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: expected results are queued when an operand
// is driven and popped when out_valid appears, alongside latency and busy checks.
module tb_shift_sequencer;

    localparam int N  = 32;
    localparam int SW = 5;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  din;
    logic [SW-1:0] shamt;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  dout;
    logic          busy;

    logic [N-1:0] exp_q[$];
    int vectors;
    int miscompares;

    shift_sequencer #(.n(N), .sw(SW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .busy      (busy)
    );

    // clock/reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one operand from IDLE and wait for its result, checking latency,
    // busy duration and the scoreboarded value.
    task automatic run_op(input string tag, input logic [N-1:0] d, input logic [SW-1:0] s,
                          input logic ordy);
        logic [N-1:0] expv;
        int exp_lat;
        int edges;
        int busy_cnt;
        expv    = d << s;
        exp_lat = 1 + (int'(s) + 1) / 2;
        check({tag, "_in_ready"}, N'(in_ready), N'(1));
        in_valid  = 1'b1;
        din       = d;
        shamt     = s;
        out_ready = ordy;
        exp_q.push_back(expv);
        step();
        in_valid = 1'b0;
        din      = N'($urandom);
        shamt    = SW'($urandom);
        edges    = 1;
        busy_cnt = 0;
        while (!out_valid && edges < 100) begin
            if (busy) busy_cnt++;
            step();
            edges++;
        end
        check({tag, "_out_valid"}, N'(out_valid), N'(1));
        check({tag, "_latency"}, N'(edges), N'(exp_lat));
        check({tag, "_busy_edges"}, N'(busy_cnt), N'((int'(s) + 1) / 2));
        if (exp_q.size() > 0) begin
            check({tag, "_dout"}, dout, exp_q.pop_front());
        end else begin
            check({tag, "_scoreboard_empty"}, N'(exp_q.size()), N'(1));
        end
    endtask

    task automatic finish_op(input string tag);
        out_ready = 1'b1;
        step();
        check({tag, "_hs_out_valid"}, N'(out_valid), N'(0));
        check({tag, "_hs_in_ready"}, N'(in_ready), N'(1));
        check({tag, "_hs_busy"}, N'(busy), N'(0));
        out_ready = 1'b0;
    endtask

    initial begin
        logic [N-1:0] rd;
        logic [SW-1:0] rs;
        logic rr;
        int seen;
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        in_valid    = 1'b0;
        din         = '0;
        shamt       = '0;
        out_ready   = 1'b0;

        #3;
        check("rst_in_ready", N'(in_ready), N'(1));
        check("rst_out_valid", N'(out_valid), N'(0));
        check("rst_busy", N'(busy), N'(0));
        check("rst_dout", dout, N'(0));
        @(posedge clk);
        step();
        reset = 1'b0;

        // First op is driven right after release, so it is accepted on the first edge.
        run_op("shamt5", 32'h0000_0001, 5'd5, 1'b1);
        finish_op("shamt5");
        run_op("msb_drop", 32'hC000_0003, 5'd2, 1'b0);
        finish_op("msb_drop");
        run_op("shamt31", 32'hFFFF_FFFF, 5'd31, 1'b0);
        finish_op("shamt31");
        run_op("shamt0", 32'h1234_5678, 5'd0, 1'b0);
        finish_op("shamt0");

        // Backpressure with ignored input pulses while holding the result.
        run_op("bp", 32'h0000_00F0, 5'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            in_valid = (i % 2 == 0);
            din      = 32'h0000_FFFF;
            shamt    = 5'd0;
            step();
            check("bp_out_valid", N'(out_valid), N'(1));
            check("bp_dout", dout, 32'h0000_0780);
            check("bp_in_ready", N'(in_ready), N'(0));
        end
        in_valid = 1'b0;
        finish_op("bp");
        check("bp_dout_held", dout, 32'h0000_0780);

        // Asynchronous reset in the middle of a shift.
        in_valid = 1'b1;
        din      = 32'hA5A5_A5A5;
        shamt    = 5'd9;
        exp_q.push_back(32'hA5A5_A5A5 << 9);
        step();
        in_valid = 1'b0;
        step();
        step();
        check("ar_busy_before", N'(busy), N'(1));
        #2 reset = 1'b1;
        #1;
        check("ar_in_ready", N'(in_ready), N'(1));
        check("ar_out_valid", N'(out_valid), N'(0));
        check("ar_busy", N'(busy), N'(0));
        check("ar_dout", dout, N'(0));
        exp_q.delete();
        #2 reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (out_valid) seen = 1;
        end
        check("ar_no_out_valid", N'(seen), N'(0));
        check("ar_idle", N'(in_ready), N'(1));

        // Back-to-back with out_ready held high and in_valid never dropped.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        din       = 32'h1;
        shamt     = 5'd1;
        exp_q.push_back(32'h2);
        step();
        din   = 32'h3;
        shamt = 5'd4;
        exp_q.push_back(32'h30);
        check("b2b_busy1", N'(busy), N'(1));
        step();
        check("b2b_valid1", N'(out_valid), N'(1));
        check("b2b_dout1", dout, exp_q.pop_front());
        step();
        check("b2b_idle", N'(in_ready), N'(1));
        check("b2b_idle_valid", N'(out_valid), N'(0));
        step();
        in_valid = 1'b0;
        check("b2b_accept2", N'(busy), N'(1));
        step();
        check("b2b_busy2", N'(busy), N'(1));
        step();
        check("b2b_valid2", N'(out_valid), N'(1));
        check("b2b_dout2", dout, exp_q.pop_front());
        step();
        check("b2b_end_idle", N'(in_ready), N'(1));
        out_ready = 1'b0;

        // A few random operands.
        for (int i = 0; i < 6; i++) begin
            rd = N'($urandom);
            rs = SW'($urandom_range(0, 31));
            rr = 1'($urandom_range(0, 1));
            run_op("rand", rd, rs, rr);
            finish_op("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
